// File: rtl/key_conditioner.sv
// Synchronizes and debounces the Run/Clear push-buttons and synchronizes the switch bus.
// Define AUTO_REPEAT_EN to add hold-to-repeat Run_Accumulate strobes.
module key_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SYNC_STAGES     = 2,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       Run_Key_n,
  input  logic       Clear_Key_n,
  input  logic [9:0] SW_raw,
  output logic [9:0] SW,
  output logic       Run_Accumulate,
  output logic       Reset_Clear,
  output logic       Run_Held,
  output logic       Clear_Held
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  if (DEBOUNCE_CYCLES < 2 || SYNC_STAGES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
    $error("key_conditioner: parameter out of range");
  end

  typedef enum logic [1:0] {RELEASED, PRESS_PEND, PRESSED, RELEASE_PEND} key_state_e;

  // Index 0 is the Run key, index 1 is the Clear key.
  logic [1:0]       key_sync_q [SYNC_STAGES];
  logic [1:0]       key_sync_d [SYNC_STAGES];
  logic [9:0]       sw_sync_q  [SYNC_STAGES];
  logic [9:0]       sw_sync_d  [SYNC_STAGES];
  key_state_e       state_q    [2];
  key_state_e       state_d    [2];
  logic [CNT_W-1:0] cnt_q      [2];
  logic [CNT_W-1:0] cnt_d      [2];
  logic [1:0]       held_q, held_d;
  logic [1:0]       press_evt;
  logic             run_acc_q, run_acc_d;
  logic             clr_stb_q, clr_stb_d;
  logic             rep_evt;
  logic [1:0]       key_s;

  always_comb begin
    key_sync_d[0] = {Clear_Key_n, Run_Key_n};
    sw_sync_d[0]  = SW_raw;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      key_sync_d[i] = key_sync_q[i-1];
      sw_sync_d[i]  = sw_sync_q[i-1];
    end
  end

  assign key_s = key_sync_q[SYNC_STAGES-1];

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      state_d[k]   = state_q[k];
      cnt_d[k]     = cnt_q[k];
      press_evt[k] = 1'b0;
      case (state_q[k])
        RELEASED: begin
          if (!key_s[k]) begin
            state_d[k] = PRESS_PEND;
            cnt_d[k]   = CNT_ONE;
          end
        end
        PRESS_PEND: begin
          if (key_s[k]) begin
            state_d[k] = RELEASED;
            cnt_d[k]   = '0;
          end else if (cnt_q[k] == CNT_MAX) begin
            state_d[k]   = PRESSED;
            cnt_d[k]     = '0;
            press_evt[k] = 1'b1;
          end else begin
            cnt_d[k] = cnt_q[k] + CNT_ONE;
          end
        end
        PRESSED: begin
          if (key_s[k]) begin
            state_d[k] = RELEASE_PEND;
            cnt_d[k]   = CNT_ONE;
          end
        end
        RELEASE_PEND: begin
          if (!key_s[k]) begin
            state_d[k] = PRESSED;
            cnt_d[k]   = '0;
          end else if (cnt_q[k] == CNT_MAX) begin
            state_d[k] = RELEASED;
            cnt_d[k]   = '0;
          end else begin
            cnt_d[k] = cnt_q[k] + CNT_ONE;
          end
        end
        default: begin
          state_d[k] = RELEASED;
          cnt_d[k]   = '0;
        end
      endcase
      held_d[k] = (state_d[k] == PRESSED) || (state_d[k] == RELEASE_PEND);
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX + 1);

  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             rep_periodic_q, rep_periodic_d;

  // Counts only while Run stays solidly pressed and Clear is not held.
  always_comb begin
    rep_cnt_d      = '0;
    rep_periodic_d = 1'b0;
    rep_evt        = 1'b0;
    if (state_q[0] == PRESSED && state_d[0] == PRESSED && !held_q[1]) begin
      rep_periodic_d = rep_periodic_q;
      rep_cnt_d      = rep_cnt_q + REP_W'(1);
      if (rep_cnt_d == (rep_periodic_q ? REP_W'(REPEAT_PERIOD) : REP_W'(REPEAT_DELAY))) begin
        rep_evt        = 1'b1;
        rep_cnt_d      = '0;
        rep_periodic_d = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rep_cnt_q      <= '0;
      rep_periodic_q <= 1'b0;
    end else begin
      rep_cnt_q      <= rep_cnt_d;
      rep_periodic_q <= rep_periodic_d;
    end
  end
`else
  assign rep_evt = 1'b0;
`endif

  // Clear wins any collision and masks Run for as long as it is held.
  always_comb begin
    run_acc_d = (press_evt[0] | rep_evt) & ~held_d[1];
    clr_stb_d = press_evt[1];
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        key_sync_q[i] <= 2'b11;
        sw_sync_q[i]  <= '0;
      end
      for (int k = 0; k < 2; k++) begin
        state_q[k] <= RELEASED;
        cnt_q[k]   <= '0;
      end
      held_q    <= '0;
      run_acc_q <= 1'b0;
      clr_stb_q <= 1'b0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        key_sync_q[i] <= key_sync_d[i];
        sw_sync_q[i]  <= sw_sync_d[i];
      end
      for (int k = 0; k < 2; k++) begin
        state_q[k] <= state_d[k];
        cnt_q[k]   <= cnt_d[k];
      end
      held_q    <= held_d;
      run_acc_q <= run_acc_d;
      clr_stb_q <= clr_stb_d;
    end
  end

  assign SW             = sw_sync_q[SYNC_STAGES-1];
  assign Run_Accumulate = run_acc_q;
  assign Reset_Clear    = clr_stb_q;
  assign Run_Held       = held_q[0];
  assign Clear_Held     = held_q[1];

endmodule

// File: tb/tb_key_conditioner.sv
// Randomized and directed bench for key_conditioner against a run-length reference model.
module tb_key_conditioner;

  localparam int D  = 4;
  localparam int S  = 2;
  localparam int RD = 10;
  localparam int RP = 3;
`ifdef AUTO_REPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic       Clk;
  logic       Reset_n = 1'b0;
  logic       Run_Key_n = 1'b1;
  logic       Clear_Key_n = 1'b1;
  logic [9:0] SW_raw = '0;
  logic [9:0] SW;
  logic       Run_Accumulate, Reset_Clear, Run_Held, Clear_Held;

  key_conditioner #(
    .DEBOUNCE_CYCLES(D), .SYNC_STAGES(S), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Run_Key_n(Run_Key_n), .Clear_Key_n(Clear_Key_n),
    .SW_raw(SW_raw), .SW(SW), .Run_Accumulate(Run_Accumulate), .Reset_Clear(Reset_Clear),
    .Run_Held(Run_Held), .Clear_Held(Clear_Held)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference model: inputs delayed through queues, each key's debounced level flips
  // once the opposite value has been seen for D+1 consecutive samples.
  logic [1:0] kq[$];
  logic [9:0] swq[$];
  bit         m_level [2];
  int         m_run   [2];
  bit         m_press [2];
  int         m_age;
  bit         m_clr_prev;
  bit         was_st, now_st, m_rep;
  logic [1:0] ks;
  logic       exp_run, exp_clr;
  logic [9:0] exp_sw;

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      kq.delete();
      swq.delete();
      for (int i = 0; i < S; i++) kq.push_back(2'b11);
      for (int i = 0; i < S - 1; i++) swq.push_back(10'h000);
      for (int k = 0; k < 2; k++) begin
        m_level[k] = 1'b0;
        m_run[k]   = 0;
        m_press[k] = 1'b0;
      end
      m_age = 0; m_clr_prev = 1'b0;
      exp_run = 1'b0; exp_clr = 1'b0; exp_sw = '0;
    end else begin
      kq.push_back({Clear_Key_n, Run_Key_n});
      ks = kq.pop_front();
      swq.push_back(SW_raw);
      exp_sw = swq.pop_front();
      was_st = m_level[0] && (m_run[0] == 0);
      for (int k = 0; k < 2; k++) begin
        m_press[k] = 1'b0;
        if ((ks[k] == 1'b0) == m_level[k]) m_run[k] = 0;
        else m_run[k] = m_run[k] + 1;
        if (m_run[k] == D + 1) begin
          m_level[k] = !m_level[k];
          m_run[k]   = 0;
          m_press[k] = m_level[k];
        end
      end
      now_st = m_level[0] && (m_run[0] == 0);
      m_rep = 1'b0;
      if (was_st && now_st && !m_clr_prev) begin
        m_age = m_age + 1;
        m_rep = AR && ((m_age == RD) || (m_age > RD && ((m_age - RD) % RP) == 0));
      end else begin
        m_age = 0;
      end
      exp_run    = (m_press[0] || m_rep) && !m_level[1];
      exp_clr    = m_press[1];
      m_clr_prev = m_level[1];
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int run_cnt, clr_cnt, held_first, held_last;
  int run_q[$];
  int clr_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h cyc=%0d", tag, got, want, cyc);
    end
  endtask

  task automatic clr_stats();
    run_cnt = 0; clr_cnt = 0; held_first = -1; held_last = -1;
    run_q.delete(); clr_q.delete();
  endtask

  task automatic tick();
    @(negedge Clk);
    cyc++;
    chk("run_acc",     {31'd0, Run_Accumulate}, {31'd0, exp_run});
    chk("reset_clear", {31'd0, Reset_Clear},    {31'd0, exp_clr});
    chk("run_held",    {31'd0, Run_Held},       {31'd0, m_level[0]});
    chk("clear_held",  {31'd0, Clear_Held},     {31'd0, m_level[1]});
    chk("sw",          {22'd0, SW},             {22'd0, exp_sw});
    if (Run_Accumulate === 1'b1) begin run_cnt++; run_q.push_back(cyc); end
    if (Reset_Clear === 1'b1) begin clr_cnt++; clr_q.push_back(cyc); end
    if (Run_Held === 1'b1) begin
      if (held_first < 0) held_first = cyc;
      held_last = cyc;
    end
  endtask

  function automatic int first_off(input int q[$], input int c);
    return (q.size() > 0) ? q[0] - c - 1 : -1;
  endfunction

  int c, r;
  int rem [2];
  logic [1:0] kv;

  initial begin
    clr_stats();
    // Reset held with Run pressed and switches all high
    Run_Key_n = 1'b0; SW_raw = 10'h3FF;
    repeat (3) begin
      tick();
      chk("rst_run_acc", {31'd0, Run_Accumulate}, 32'd0);
      chk("rst_sw", {22'd0, SW}, 32'd0);
      chk("rst_held", {30'd0, Run_Held, Clear_Held}, 32'd0);
    end
    Reset_n = 1'b1; c = cyc; clr_stats();
    tick(); chk("sw_lat1", {22'd0, SW}, 32'd0);
    tick(); chk("sw_lat2", {22'd0, SW}, 32'h3FF);
    repeat (8) tick();
    chk("rst_run_cnt", run_cnt, 1);
    chk("rst_run_off", first_off(run_q, c), 6);
    Run_Key_n = 1'b1; repeat (12) tick();

    // Clean press
    clr_stats(); Run_Key_n = 1'b0; c = cyc;
    repeat (20) tick();
    Run_Key_n = 1'b1; r = cyc;
    repeat (12) tick();
    chk("clean_cnt", run_cnt, AR ? 2 : 1);
    chk("clean_off", first_off(run_q, c), 6);
    chk("held_rise", held_first, (run_q.size() > 0) ? run_q[0] : -1);
    chk("held_fall", held_last - r, 6);

    // Bounce: five short lows separated by one-cycle gaps
    clr_stats();
    repeat (5) begin
      Run_Key_n = 1'b0; repeat (3) tick();
      Run_Key_n = 1'b1; tick();
    end
    Run_Key_n = 1'b0; c = cyc;
    repeat (14) tick();
    Run_Key_n = 1'b1; repeat (12) tick();
    chk("bounce_cnt", run_cnt, 1);
    chk("bounce_off", first_off(run_q, c), 6);

    // Simultaneous press
    clr_stats(); Run_Key_n = 1'b0; Clear_Key_n = 1'b0; c = cyc;
    repeat (20) tick();
    Run_Key_n = 1'b1; Clear_Key_n = 1'b1; repeat (12) tick();
    chk("simul_clr_cnt", clr_cnt, 1);
    chk("simul_run_cnt", run_cnt, 0);
    chk("simul_clr_off", first_off(clr_q, c), 6);

    // Long hold for auto-repeat
    clr_stats(); Run_Key_n = 1'b0; c = cyc;
    repeat (34) tick();
    Run_Key_n = 1'b1; repeat (12) tick();
    chk("rep_cnt", run_cnt, AR ? 8 : 1);
    chk("rep_off", first_off(run_q, c), 6);
    chk("rep_gap", (run_q.size() > 1) ? run_q[1] - run_q[0] : 0, AR ? 10 : 0);
    chk("rep_span", (run_q.size() > 0) ? run_q[run_q.size()-1] - run_q[0] : -1, AR ? 28 : 0);

    // Reset pulse while the press is still pending
    clr_stats(); Run_Key_n = 1'b0;
    repeat (4) tick();
    Reset_n = 1'b0; tick();
    Reset_n = 1'b1; c = cyc;
    repeat (10) tick();
    Run_Key_n = 1'b1; repeat (12) tick();
    chk("midrst_cnt", run_cnt, 1);
    chk("midrst_off", first_off(run_q, c), 6);

    // Random keys, switches and occasional resets
    kv = 2'b11; rem[0] = 1; rem[1] = 1;
    for (int n = 0; n < 1200; n++) begin
      for (int k = 0; k < 2; k++) begin
        if (rem[k] == 0) begin
          kv[k] = ~kv[k];
          rem[k] = ($urandom_range(0, 2) == 0) ? $urandom_range(8, 40) : $urandom_range(1, 6);
        end
        rem[k]--;
      end
      Run_Key_n = kv[0]; Clear_Key_n = kv[1];
      SW_raw = 10'($urandom);
      Reset_n = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1);
  end

endmodule

// File: doc/key_conditioner.md
# key_conditioner

Front-end input conditioner for the accumulator datapath. It synchronizes the raw, active-low push-buttons and the slide switches, then debounces both buttons. It produces clean single-cycle Run_Accumulate and Reset_Clear pulses, plus a stable synchronized switch bus, all feeding the accumulator stage directly. Per-key debounce state machines guarantee exactly one accumulate or clear event per physical press.

## Interface
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a key change (10 ms at 50 MHz); minimum 2
- SYNC_STAGES, 2, flip-flop depth of every input synchronizer; minimum 2
- REPEAT_DELAY, 25000000, cycles a Run key must be held before the first auto-repeat pulse (only with AUTO_REPEAT_EN)
- REPEAT_PERIOD, 5000000, cycles between subsequent auto-repeat pulses (only with AUTO_REPEAT_EN)
- Clk  input  1  system clock, all state on rising edge
- Reset_n  input  1  asynchronous, active-low reset
- Run_Key_n  input  1  raw Run button, active-low, asynchronous to Clk
- Clear_Key_n  input  1  raw Clear button, active-low, asynchronous to Clk
- SW_raw  input  10  raw slide switches, asynchronous to Clk
- SW  output  10  synchronized switch value, to the accumulator operand input
- Run_Accumulate  output  1  one-cycle accumulate strobe
- Reset_Clear  output  1  one-cycle clear strobe
- Run_Held  output  1  debounced level: Run key currently pressed
- Clear_Held  output  1  debounced level: Clear key currently pressed

## Operation
- Synchronizers:
  - Each key input passes through SYNC_STAGES flops, reset to 1 (released).
  - SW_raw passes through SYNC_STAGES flops, reset to 0.
  - SW is the final synchronizer stage. SW is not debounced.
- Each key has an independent FSM: RELEASED, PRESS_PEND, PRESSED, RELEASE_PEND.
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
  - RELEASED: synchronized key == 0 -> PRESS_PEND, counter = 1.
  - PRESS_PEND: key == 0 increments the counter. When the counter reaches DEBOUNCE_CYCLES -> PRESSED and the press strobe fires. Key == 1 at any point -> RELEASED, counter = 0.
  - PRESSED: key == 1 -> RELEASE_PEND, counter = 1.
  - RELEASE_PEND: symmetric to PRESS_PEND. Completion -> RELEASED with no strobe. Key == 0 -> PRESSED, counter = 0.
- Run_Held and Clear_Held are 1 in PRESSED and RELEASE_PEND.
- Strobes:
  - A strobe is 1 for exactly the cycle the FSM is in its first cycle of PRESSED following PRESS_PEND.
  - Returning to PRESSED from RELEASE_PEND never strobes.
- Priority: if both strobes would assert in the same cycle, Reset_Clear asserts and that Run_Accumulate strobe is dropped, not deferred.
- Run_Accumulate is forced 0 in any cycle where Clear_Held == 1.
- Reset mid-operation:
  - All FSMs go to RELEASED, counters to 0, all outputs to 0 immediately (asynchronous assert).
  - A key still held at deassertion must complete a full debounce to produce a strobe.

## Timing
- Reset values:
  - SW = 0, Run_Accumulate = 0, Reset_Clear = 0, Run_Held = 0, Clear_Held = 0.
  - FSM state = RELEASED, all counters = 0.
- Press latency: a raw key held low continuously from before rising edge 0 produces its strobe in the cycle after edge SYNC_STAGES+DEBOUNCE_CYCLES.
- Release latency: Held drops SYNC_STAGES+DEBOUNCE_CYCLES cycles after a clean release.
- SW latency is SYNC_STAGES cycles.
- Glitch rejection: any key pulse, bounce or gap shorter than DEBOUNCE_CYCLES cycles at the synchronizer output produces no state change and no strobe.
- Counters saturate at DEBOUNCE_CYCLES and never wrap.
- Strobes are never wider than one cycle. A minimum of 2*DEBOUNCE_CYCLES cycles separates two manual strobes on the same key.

## Configuration
- AUTO_REPEAT_EN defined:
  - While the Run FSM stays in PRESSED, a repeat counter runs.
  - An extra Run_Accumulate strobe fires REPEAT_DELAY cycles after the press strobe, then every REPEAT_PERIOD cycles.
  - Entering RELEASE_PEND, or Clear_Held == 1, resets the repeat counter to 0. Repeat restarts from REPEAT_DELAY once back in PRESSED.
  - Priority and Clear_Held masking rules apply to repeat strobes.
- AUTO_REPEAT_EN undefined:
  - No repeat counter is present, and REPEAT_DELAY and REPEAT_PERIOD are ignored.
  - Exactly one Run_Accumulate strobe per debounced press.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, SYNC_STAGES=2, REPEAT_DELAY=10, REPEAT_PERIOD=3.
- Reset: hold Reset_n=0 for 3 cycles with keys pressed and SW_raw=10'h3FF -> all outputs 0. After release: SW=10'h3FF two cycles later; Run_Accumulate strobes at cycle 6 after reset deassertion.
- Clean press: Run_Key_n low for 20 cycles -> Run_Accumulate high exactly once, 6 cycles after the falling edge. Run_Held high from that cycle until 6 cycles after the key rises.
- Bounce: Run_Key_n toggles low 3 cycles / high 1 cycle, five times, then stays low -> exactly one strobe, 6 cycles after the final falling edge.
- Simultaneous: both keys fall on the same edge and are held -> Reset_Clear strobes once; Run_Accumulate stays 0 throughout.
- Auto-repeat (AUTO_REPEAT_EN):
  - Run held 30 cycles past the press strobe -> strobes at +0, +10, +13, +16, ..., +28.
  - Without the macro -> only the +0 strobe.
- Mid-debounce reset: Reset_n pulsed low during PRESS_PEND -> no strobe from that press. A strobe follows 6 cycles after Reset_n rises if the key is still held.
